// File: rtl/umi_port_router_if.sv
// umi_port_router_if: one UMI beat channel (valid/ready plus cmd, addresses and data).
// VW is 1 on the upstream side and M on the one-hot switch side.
interface umi_port_router_if #(
    parameter int VW = 1,
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 128
);
    logic [VW-1:0] valid;
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
    logic          ready;
    modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
    modport slave (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_port_router.sv
// umi_port_router: decodes and locks the destination port per transaction, buffers beats in a
// 2-entry FIFO and drives the one-hot switch request; illegal transactions are dropped and counted.
module umi_port_router #(
    parameter int M       = 4,
    parameter int DW      = 128,
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int IDSB    = 40,
    parameter int IDW     = 4,
    parameter int DEFPORT = M
) (
    input  logic                 clk,
    input  logic                 nreset,
    umi_port_router_if.slave     umi_in,
    umi_port_router_if.master    umi_out,
    output logic [15:0]          drop_count
);
    localparam int TW = $clog2(M);
    localparam bit DEF_OK = DEFPORT < M;
    localparam logic [TW-1:0] DEF_T = DEF_OK ? TW'(DEFPORT) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
        logic [TW-1:0] tgt;
    } entry_t;

    state_t        state;
    logic [TW-1:0] tgt;
    entry_t        mem [2];
    logic          wp, rp, en;
    logic [1:0]    cnt;
    logic [IDW-1:0] id;
    logic          legal, first_drop, acc, push, pop, eom, full, cnt_drop;
    logic [TW-1:0] btgt;

    assign id         = umi_in.dstaddr[IDSB +: IDW];
    assign eom        = umi_in.cmd[22];
    assign legal      = int'(id) < M;
    assign first_drop = state == IDLE && !legal && !DEF_OK;
    assign btgt       = state == BUSY ? tgt : legal ? id[TW-1:0] : DEF_T;
    assign full       = cnt == 2'd2;
    // en keeps ready low during reset and for the first edge after release
    assign umi_in.ready = en & (state == DROP | !full);
    assign acc        = umi_in.valid & umi_in.ready;
    assign push       = acc & state != DROP & !first_drop;
    assign pop        = cnt != 2'd0 & umi_out.ready;
    assign cnt_drop   = acc & eom & (state == DROP | first_drop);

    assign umi_out.valid   = cnt != 2'd0 ? M'(1) << mem[rp].tgt : '0;
    assign umi_out.cmd     = mem[rp].cmd;
    assign umi_out.dstaddr = mem[rp].dst;
    assign umi_out.srcaddr = mem[rp].src;
    assign umi_out.data    = mem[rp].data;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            tgt        <= '0;
            wp         <= 1'b0;
            rp         <= 1'b0;
            cnt        <= 2'd0;
            en         <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            en  <= 1'b1;
            cnt <= cnt + 2'(push) - 2'(pop);
            if (push) begin
                mem[wp] <= '{umi_in.cmd, umi_in.dstaddr, umi_in.srcaddr, umi_in.data, btgt};
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            if (cnt_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (acc) begin
                tgt   <= btgt;
                state <= eom ? IDLE : state == IDLE ? (first_drop ? DROP : BUSY) : state;
            end
        end
    end
endmodule
